// File: rtl/lsu_serializer.sv
// lsu_serializer
//
// Turns one warp-wide load/store into LANES sequential accesses on a
// single-port data memory. Each serviced lane takes three cycles
// (ADDR, ACCESS, CAPTURE). A single-cycle DONE follows the last lane, and then
// the block returns to IDLE. The request is latched when it is accepted, so the
// core may change req_* freely while the block is busy.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-low reset
//   req_valid    core presents a request (accepted in IDLE)
//   req_we       1 = store, 0 = load
//   req_addr     per-lane addresses, lane k at [k*ADDR_W +: ADDR_W]
//   req_wdata    per-lane store data, lane k at [k*DATA_W +: DATA_W]
//   req_mask     per-lane enable (only with LSU_ACTIVE_MASK_EN)
//   req_ready    high only in IDLE
//   stall        core issue hold: busy, or request pending in IDLE
//   done         one-cycle completion pulse
//   lane_rdata   gathered load results
//   mem_*        single-port memory; mem_rdata valid the cycle after mem_re
//
// Build option
//   LSU_ACTIVE_MASK_EN  adds req_mask. Masked-off lanes are skipped in zero
//                       cycles. An all-zero mask goes from accept directly to
//                       DONE.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for req_valid; req_ready high
// ADDR     | present lane address/data, no strobes
// ACCESS   | strobe mem_we (store) or mem_re (load)
// CAPTURE  | loads latch mem_rdata into the lane slice
// DONE     | done pulse, back to IDLE next cycle

module lsu_serializer #(
   parameter int LANES  = 16,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   input  logic                    req_we,
   input  logic [LANES*ADDR_W-1:0] req_addr,
   input  logic [LANES*DATA_W-1:0] req_wdata,
`ifdef LSU_ACTIVE_MASK_EN
   input  logic [LANES-1:0]        req_mask,
`endif
   output logic                    req_ready,
   output logic                    stall,
   output logic                    done,
   output logic [LANES*DATA_W-1:0] lane_rdata,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic                    mem_we,
   output logic                    mem_re,
   input  logic [DATA_W-1:0]       mem_rdata
);

   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ACCESS,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [LIDX_W-1:0]       lane_q, lane_d;
   logic                    we_q, we_d;
   logic [LANES*ADDR_W-1:0] addr_q, addr_d;
   logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
   logic [LANES*DATA_W-1:0] rdata_q, rdata_d;

   logic [LANES-1:0]        accept_mask;
   logic [LANES-1:0]        active_mask;
   logic [LIDX_W:0]         first_lane;
   logic [LIDX_W:0]         next_lane;

   // Returns {found, index} for the lowest set bit of m at position >= from.
   function automatic logic [LIDX_W:0] find_lane(input logic [LANES-1:0] m,
                                                 input int from);
      logic [LIDX_W:0] r;
      r = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (m[i] && (i >= from)) begin
            r = {1'b1, i[LIDX_W-1:0]};
         end
      end
      return r;
   endfunction

`ifdef LSU_ACTIVE_MASK_EN
   logic [LANES-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if ((state_q == S_IDLE) && req_valid) begin
         mask_d = req_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

   assign accept_mask = req_mask;
   assign active_mask = mask_q;
`else
   assign accept_mask = '1;
   assign active_mask = '1;
`endif

   assign first_lane = find_lane(accept_mask, 0);
   // Searching only above the current lane means the index can never wrap.
   assign next_lane  = find_lane(active_mask, int'(lane_q) + 1);

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (first_lane[LIDX_W]) begin
                  lane_d  = first_lane[LIDX_W-1:0];
                  state_d = S_ADDR;
               end else begin
                  lane_d  = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_ADDR: begin
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (!we_q) begin
               rdata_d[lane_q*DATA_W +: DATA_W] = mem_rdata;
            end
            if (next_lane[LIDX_W]) begin
               lane_d  = next_lane[LIDX_W-1:0];
               state_d = S_ADDR;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            lane_d  = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      req_ready = (state_q == S_IDLE);
      stall     = (state_q != S_IDLE) || req_valid;
      done      = (state_q == S_DONE);
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if ((state_q == S_ADDR) || (state_q == S_ACCESS) || (state_q == S_CAPTURE)) begin
         mem_addr  = addr_q[lane_q*ADDR_W +: ADDR_W];
         mem_wdata = wdata_q[lane_q*DATA_W +: DATA_W];
      end
      // The memory samples its strobes on the same edge that applies reset.
      // Gating with reset keeps an interrupted ACCESS from writing.
      if ((state_q == S_ACCESS) && reset) begin
         mem_we = we_q;
         mem_re = !we_q;
      end
   end

   assign lane_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_serializer.sv
module tb_lsu_serializer;
   localparam int LANES  = 16;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int VW     = LANES * DATA_W;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    req_valid;
   logic                    req_we;
   logic [LANES*ADDR_W-1:0] req_addr;
   logic [LANES*DATA_W-1:0] req_wdata;
`ifdef LSU_ACTIVE_MASK_EN
   logic [LANES-1:0]        req_mask;
`endif
   logic                    req_ready;
   logic                    stall;
   logic                    done;
   logic [LANES*DATA_W-1:0] lane_rdata;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    mem_we;
   logic                    mem_re;
   logic [DATA_W-1:0]       mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_serializer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
`ifdef LSU_ACTIVE_MASK_EN
      .req_mask   (req_mask),
`endif
      .req_ready  (req_ready),
      .stall      (stall),
      .done       (done),
      .lane_rdata (lane_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata)
   );

   // Data memory model: 4K words, read data registered one cycle after mem_re.
   logic [DATA_W-1:0] mem [0:4095] = '{default: '0};

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[11:0]];
   end

   // Bus monitor.
   logic [ADDR_W-1:0] strobe_q [$];
   int overlap_cnt = 0;
   int done_cnt    = 0;

   always @(posedge clk) begin
      if (mem_we || mem_re) strobe_q.push_back(mem_addr);
      if (mem_we && mem_re) overlap_cnt++;
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE. Returns at the negedge of the IDLE cycle
   // after DONE, which leaves the caller free to issue a back-to-back request.
   task automatic run_op(input string tag, input logic we,
                         input logic [LANES*ADDR_W-1:0] addr,
                         input logic [LANES*DATA_W-1:0] wdata,
                         input logic [LANES-1:0] mask,
                         input bit hold, input bit garble,
                         input logic [LANES*ADDR_W-1:0] garb_addr,
                         output int cycles);
      int base;
      int bad;
      int j;
      base = strobe_q.size();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
`ifdef LSU_ACTIVE_MASK_EN
      req_mask  = mask;
`endif
      #1;
      check({tag, "_accept_ready"}, req_ready, 1'b1);
      check({tag, "_accept_stall"}, stall, 1'b1);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      if (garble) begin
         req_we    = 1'b1;
         req_addr  = garb_addr;
         req_wdata = '1;
      end
      cycles = 0;
      bad    = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (!stall || req_ready) bad++;
      end while (!done && cycles < 200);
      check({tag, "_busy_stall_ready"}, bad, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 1'b0);
      check({tag, "_idle_ready"}, req_ready, 1'b1);
      bad = 0;
      j   = base;
      for (int k = 0; k < LANES; k++) begin
         if (mask[k]) begin
            if (j >= strobe_q.size()) bad++;
            else if (strobe_q[j] !== addr[k*ADDR_W +: ADDR_W]) bad++;
            j++;
         end
      end
      check({tag, "_strobe_count"}, strobe_q.size() - base, $countones(mask));
      check({tag, "_strobe_order"}, bad, 0);
      check({tag, "_no_overlap"}, overlap_cnt, 0);
   endtask

   logic [LANES*ADDR_W-1:0] a_100, a_200, a_300, a_400;
   logic [LANES*DATA_W-1:0] d_k, d_a0, d_50, exp_rd;
   int cyc;
   int bad;
   int dc;

   initial begin
      for (int k = 0; k < LANES; k++) begin
         a_100[k*ADDR_W +: ADDR_W] = 16'h0100 + 16'(k);
         a_200[k*ADDR_W +: ADDR_W] = 16'h0200 + 16'(k);
         a_300[k*ADDR_W +: ADDR_W] = 16'h0300 + 16'(k);
         a_400[k*ADDR_W +: ADDR_W] = 16'h0400 + 16'(k);
         d_k[k*DATA_W +: DATA_W]   = 16'(k);
         d_a0[k*DATA_W +: DATA_W]  = 16'h00A0 + 16'(k);
         d_50[k*DATA_W +: DATA_W]  = 16'h0050 + 16'(k);
      end

      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
`ifdef LSU_ACTIVE_MASK_EN
      req_mask  = '1;
`endif
      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 1'b1);
      check("rst_stall", stall, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rdata", lane_rdata, '0);
      check("rst_mem_addr", mem_addr, '0);
      check("rst_mem_wdata", mem_wdata, '0);
      check("rst_strobes", {mem_we, mem_re}, 2'b00);
      reset = 1'b1;
      @(negedge clk);

      // Store lane k -> 0x0100+k = k, then load back.
      run_op("st1", 1'b1, a_100, d_k, '1, 1'b0, 1'b0, '0, cyc);
      check("st1_cycles", cyc, 49);
      check("st1_rdata_unchanged", lane_rdata, '0);
      bad = 0;
      for (int k = 0; k < LANES; k++) if (mem[12'h100 + 12'(k)] !== 16'(k)) bad++;
      check("st1_mem_contents", bad, 0);

      run_op("ld1", 1'b0, a_100, '0, '1, 1'b0, 1'b0, '0, cyc);
      check("ld1_cycles", cyc, 49);
      check("ld1_rdata", lane_rdata, d_k);

      // Hold req_valid through a store while garbling req_*. The next request
      // goes in the first IDLE cycle.
      run_op("st2", 1'b1, a_200, d_a0, '1, 1'b1, 1'b1, a_300, cyc);
      check("st2_cycles", cyc, 49);
      check("st2_idle_stall_held", stall, 1'b1);
      run_op("ld2", 1'b0, a_200, '0, '1, 1'b0, 1'b0, '0, cyc);
      check("ld2_cycles", cyc, 49);
      check("ld2_rdata", lane_rdata, d_a0);
      bad = 0;
      for (int k = 0; k < LANES; k++) if (mem[12'h300 + 12'(k)] !== 16'h0000) bad++;
      check("garbage_not_written", bad, 0);

      // Reset during lane 5 ADDR of a store.
      dc = done_cnt;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = a_400;
      req_wdata = d_50;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("rst5_lane5_addr", mem_addr, 16'h0405);
      check("rst5_lane5_strobes", {mem_we, mem_re}, 2'b00);
      reset = 1'b0;
      @(negedge clk);
      check("rst5_idle", req_ready, 1'b1);
      check("rst5_rdata_zero", lane_rdata, '0);
      check("rst5_mem_addr", mem_addr, '0);
      check("rst5_done_low", done, 1'b0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst5_no_done", done_cnt - dc, 0);
      check("rst5_still_idle", req_ready, 1'b1);
      bad = 0;
      for (int k = 0; k < LANES; k++) begin
         if (k < 5 && mem[12'h400 + 12'(k)] !== 16'h0050 + 16'(k)) bad++;
         if (k >= 5 && mem[12'h400 + 12'(k)] !== 16'h0000) bad++;
      end
      check("rst5_mem_lanes", bad, 0);

      // Full load after the abort still works.
      run_op("ld3", 1'b0, a_100, '0, '1, 1'b0, 1'b0, '0, cyc);
      check("ld3_cycles", cyc, 49);
      check("ld3_rdata", lane_rdata, d_k);

`ifdef LSU_ACTIVE_MASK_EN
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_op("m_f0", 1'b0, a_100, '0, 16'h00F0, 1'b0, 1'b0, '0, cyc);
      check("m_f0_cycles", cyc, 13);
      exp_rd = '0;
      for (int k = 4; k < 8; k++) exp_rd[k*DATA_W +: DATA_W] = 16'(k);
      check("m_f0_rdata", lane_rdata, exp_rd);
      dc = strobe_q.size();
      run_op("m_00", 1'b0, a_100, '0, 16'h0000, 1'b0, 1'b0, '0, cyc);
      check("m_00_cycles", cyc, 1);
      check("m_00_no_strobes", strobe_q.size() - dc, 0);
      check("m_00_rdata", lane_rdata, exp_rd);
`else
      exp_rd = '0;
`endif

      check("final_overlap", overlap_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_serializer.md
LSU_SERIALIZER -- requirements
Module: lsu_serializer

Interface
REQ-001 SHALL have parameter LANES, default 16: number of SIMD lanes serviced per request.
REQ-002 SHALL have parameter DATA_W, default 16: per-lane data width.
REQ-003 SHALL have parameter ADDR_W, default 16: data-memory address width.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1: core presents a warp-wide load/store.
REQ-007 SHALL have port req_we  input  1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  LANES*ADDR_W: per-lane effective address; lane k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata  input  LANES*DATA_W: per-lane store data, same packing.
REQ-010 SHALL have port req_ready  output  1: high only in IDLE.
REQ-011 SHALL have port stall  output  1: core PC/issue hold.
REQ-012 SHALL have port done  output  1: single-cycle completion pulse.
REQ-013 SHALL have port lane_rdata  output  LANES*DATA_W: gathered load results.
REQ-014 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_we (output, 1), mem_re (output, 1), mem_rdata (input, DATA_W): single-port data memory; read data valid the cycle after mem_re.

Function
REQ-015 SHALL implement states IDLE, ADDR, ACCESS, CAPTURE, DONE.
REQ-016 SHALL accept a request on a rising edge with req_valid=1 in IDLE: latch req_we, req_addr, req_wdata; clear lane index to 0; go to ADDR.
REQ-017 SHALL ignore req_* while not IDLE; latched copies alone drive the operation.
REQ-018 Per lane SHALL spend exactly 3 cycles: ADDR (mem_addr = lane address, mem_wdata = lane data, mem_we = mem_re = 0), ACCESS (address/data held, mem_we = latched we, mem_re = ~latched we), CAPTURE (strobes 0; load writes mem_rdata into that lane's lane_rdata slice).
REQ-019 From CAPTURE SHALL go to ADDR with lane index + 1, or to DONE when the index is LANES-1; lane index SHALL NOT wrap past LANES-1.
REQ-020 In DONE SHALL assert done for exactly one cycle, then return to IDLE; with all lanes serviced, accept-to-IDLE takes 3*LANES+1 cycles (49 at default).
REQ-021 stall SHALL equal (state != IDLE) OR (state == IDLE AND req_valid), so the core holds in the accept cycle.
REQ-022 Stores SHALL leave lane_rdata unchanged.
REQ-023 Lanes not serviced SHALL retain their previous lane_rdata.
REQ-024 Back-to-back requests SHALL be accepted no earlier than the first IDLE cycle after DONE.
REQ-025 mem_we and mem_re SHALL never be high together, and SHALL be high only in ACCESS.

Reset
REQ-026 reset=0 on a clock edge SHALL force IDLE, lane index 0 and lane_rdata all zeros, and SHALL deassert done, mem_we, mem_re, mem_addr and mem_wdata (0).
REQ-027 Reset mid-operation SHALL abort with no done pulse; a store lane whose ACCESS cycle has not completed SHALL issue no write.

Configuration
REQ-028 With LSU_ACTIVE_MASK_EN defined, SHALL add input req_mask (LANES bits), latched at accept; lanes with mask bit 0 SHALL be skipped in zero cycles, giving 3*(active lanes)+1 cycles; an all-zero mask SHALL go straight from accept to DONE (done one cycle after accept).
REQ-029 Without LSU_ACTIVE_MASK_EN, req_mask SHALL NOT exist and all LANES lanes SHALL always be serviced.

Verification
REQ-030 Store with lane k addr 0x0100+k, data k, then load of same addresses -> lane_rdata lane k = k; done exactly 49 cycles after each accept.
REQ-031 Hold req_valid high through a store -> stall high from the accept cycle through DONE; req_ready low and req_* changes ignored while busy; second request accepted in the first IDLE cycle.
REQ-032 Memory monitor during any operation -> never mem_we&&mem_re; exactly 16 strobes, addresses in lane order 0..15.
REQ-033 Assert reset=0 in lane 5 ADDR of a store -> next cycle IDLE, no done, no writes to lanes 5..15, lane_rdata = 0.
REQ-034 LSU_ACTIVE_MASK_EN with mask 0x00F0 load -> only lanes 4..7 accessed and updated, done 13 cycles after accept; mask 0x0000 -> done 1 cycle after accept, no strobes.
